mdu_ctrl: RTL and testbench

//  Sequencing controller for the multiply/divide unit (MDU) in the E stage of the pipelined MIPS core.

---
 rtl/mdu_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller for the E stage: owns HI/LO, models fixed mult/div
// latency with a countdown, and requests a pipeline stall while an MDU op cannot be accepted.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_valid,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] md_rdata,
   output logic        start,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMfhi  = 4'd5;
   localparam logic [3:0] OpMflo  = 4'd6;
   localparam logic [3:0] OpMthi  = 4'd7;
   localparam logic [3:0] OpMtlo  = 4'd8;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       shadow_hi_q, shadow_hi_d;
   logic [31:0]       shadow_lo_q, shadow_lo_d;
   logic              skip_commit_q, skip_commit_d;

   // Op decode
   logic is_mul, is_div, is_signed, is_mfhi, is_mflo, is_mthi, is_mtlo, is_md_op;

   always_comb begin
      is_mul    = 1'b0;
      is_div    = 1'b0;
      is_signed = 1'b0;
      is_mfhi   = 1'b0;
      is_mflo   = 1'b0;
      is_mthi   = 1'b0;
      is_mtlo   = 1'b0;
      case (md_op)
         OpMult:  begin is_mul = 1'b1; is_signed = 1'b1; end
         OpMultu: is_mul = 1'b1;
         OpDiv:   begin is_div = 1'b1; is_signed = 1'b1; end
         OpDivu:  is_div = 1'b1;
         OpMfhi:  is_mfhi = 1'b1;
         OpMflo:  is_mflo = 1'b1;
         OpMthi:  is_mthi = 1'b1;
         OpMtlo:  is_mtlo = 1'b1;
         default: ;
      endcase
      is_md_op = is_mul | is_div | is_mfhi | is_mflo | is_mthi | is_mtlo;
   end

   logic accept_ok;
   assign accept_ok = md_valid & (state_q == StIdle);
   assign start     = accept_ok & (is_mul | is_div);
   assign stall_req = md_valid & is_md_op & busy_q;

   // Multiply: sign- or zero-extend to 64 bits and keep the low 64 bits of the product.
   logic [63:0] mul_a, mul_b, mul_prod;

   always_comb begin
      mul_a    = {{32{is_signed & rs_data[31]}}, rs_data};
      mul_b    = {{32{is_signed & rt_data[31]}}, rt_data};
      mul_prod = mul_a * mul_b;
   end

   // Divide on magnitudes, then restore signs. This truncates toward zero, gives the remainder
   // the dividend's sign, and naturally yields 0x80000000 / -1 = 0x80000000 rem 0.
   logic        dvd_neg, dvs_neg, div_by_zero;
   logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, div_q, div_r;

   always_comb begin
      dvd_neg     = is_signed & rs_data[31];
      dvs_neg     = is_signed & rt_data[31];
      div_by_zero = (rt_data == 32'd0);
      dvd_mag     = dvd_neg ? (32'd0 - rs_data) : rs_data;
      if (div_by_zero) begin
         dvs_mag = 32'd1;
      end else begin
         dvs_mag = dvs_neg ? (32'd0 - rt_data) : rt_data;
      end
      q_mag = dvd_mag / dvs_mag;
      r_mag = dvd_mag % dvs_mag;
      div_q = (dvd_neg ^ dvs_neg) ? (32'd0 - q_mag) : q_mag;
      div_r = dvd_neg ? (32'd0 - r_mag) : r_mag;
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      busy_d        = busy_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      shadow_hi_d   = shadow_hi_q;
      shadow_lo_d   = shadow_lo_q;
      skip_commit_d = skip_commit_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               busy_d = 1'b1;
               if (is_mul) begin
                  state_d       = StMul;
                  cnt_d         = CntW'(MULT_CYCLES);
                  shadow_hi_d   = mul_prod[63:32];
                  shadow_lo_d   = mul_prod[31:0];
                  skip_commit_d = 1'b0;
               end else begin
                  state_d       = StDiv;
                  cnt_d         = CntW'(DIV_CYCLES);
                  shadow_hi_d   = div_r;
                  shadow_lo_d   = div_q;
                  skip_commit_d = div_by_zero;
               end
            end else if (accept_ok && is_mthi) begin
               hi_d = rs_data;
            end else if (accept_ok && is_mtlo) begin
               lo_d = rs_data;
            end
         end

         StMul, StDiv: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               if (!skip_commit_q) begin
                  hi_d = shadow_hi_q;
                  lo_d = shadow_lo_q;
               end
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         hi_q          <= 32'd0;
         lo_q          <= 32'd0;
         shadow_hi_q   <= 32'd0;
         shadow_lo_q   <= 32'd0;
         skip_commit_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         shadow_hi_q   <= shadow_hi_d;
         shadow_lo_q   <= shadow_lo_d;
         skip_commit_q <= skip_commit_d;
      end
   end

   // Reads are gated by md_valid so an idle E stage presents zero.
   always_comb begin
      md_rdata = 32'd0;
      if (md_valid && is_mfhi) begin
         md_rdata = hi_q;
      end else if (md_valid && is_mflo) begin
         md_rdata = lo_q;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model of HI/LO and operation latency.
module tb_mdu_ctrl;

   localparam int MultCycles = 5;
   localparam int DivCycles  = 10;

   logic        clk;
   logic        reset;
   logic        md_valid;
   logic [3:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] md_rdata;
   logic        start;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;

   mdu_ctrl #(
      .MULT_CYCLES(MultCycles),
      .DIV_CYCLES (DivCycles)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .md_valid (md_valid),
      .md_op    (md_op),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .md_rdata (md_rdata),
      .start    (start),
      .busy     (busy),
      .stall_req(stall_req),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      md_valid = v;
      md_op    = op;
      rs_data  = a;
      rt_data  = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
      tick();
      reset = 1'b1;
      drive(1'b1, 4'd5, 32'd0, 32'd0);
      #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
      checks++; if (md_rdata !== 32'd0) begin errors++; $display("FAIL reset_mfhi: got %h want 0", md_rdata); end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
   endtask

   // Issue one mult/div and check start, busy length and the committed result.
   task automatic test_arith(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int cycles, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
      drive(1'b1, op, a, b);
      #1;
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL %s_start: got %b want 1", name, start); end
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      for (int i = 0; i < cycles; i++) begin
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy%0d: got %b want 1", name, i + 1, busy); end
         tick();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_done: got %b want 0", name, busy); end
      checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi: got %h want %h", name, hi, exp_hi); end
      checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo: got %h want %h", name, lo, exp_lo); end
   endtask

   task automatic test_div_stall();
      drive(1'b1, 4'd8, 32'hA5A5_A5A5, 32'd0);
      tick();
      drive(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
      #1;
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL div_start: got %b want 1", start); end
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL div_start_stall: got %b want 0", stall_req); end
      tick();
      for (int i = 1; i <= DivCycles; i++) begin
         drive(1'b1, 4'd6, 32'd0, 32'd0);
         #1;
         checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL div_stall%0d: got %b want 1", i, stall_req); end
         checks++; if (md_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL div_oldlo%0d: got %h want a5a5a5a5", i, md_rdata); end
         checks++; if (start !== 1'b0) begin errors++; $display("FAIL div_nostart%0d: got %b want 0", i, start); end
         tick();
      end
      drive(1'b1, 4'd6, 32'd0, 32'd0);
      #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL div_c11_stall: got %b want 0", stall_req); end
      checks++; if (md_rdata !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_c11_lo: got %h want fffffffd", md_rdata); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
   endtask

   task automatic test_noop_while_busy();
      drive(1'b1, 4'd1, 32'd3, 32'd4);
      tick();
      drive(1'b1, 4'd9, 32'd0, 32'd0);
      #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL noop9_stall: got %b want 0", stall_req); end
      checks++; if (md_rdata !== 32'd0) begin errors++; $display("FAIL noop9_rdata: got %h want 0", md_rdata); end
      drive(1'b0, 4'd5, 32'd0, 32'd0);
      #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL invalid_stall: got %b want 0", stall_req); end
      drive(1'b1, 4'd7, 32'hDEAD_BEEF, 32'd0);
      #1;
      checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mthi_busy_stall: got %b want 1", stall_req); end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      for (int i = 0; i < MultCycles; i++) tick();
      checks++; if (hi !== 32'd0 || lo !== 32'd12) begin
         errors++; $display("FAIL noop_result: got %h_%h want 00000000_0000000c", hi, lo);
      end
   endtask

   task automatic test_divu_zero();
      drive(1'b1, 4'd7, 32'h1234_5678, 32'd0);
      tick();
      drive(1'b1, 4'd8, 32'h0BAD_F00D, 32'd0);
      tick();
      test_arith("divu0", 4'd4, 32'h55, 32'd0, DivCycles, 32'h1234_5678, 32'h0BAD_F00D);
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 4'd7, 32'h1111_1111, 32'd0);
      tick();
      drive(1'b1, 4'd8, 32'h2222_2222, 32'd0);
      tick();
      drive(1'b1, 4'd1, 32'd100, 32'd7);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      tick();
      #3;
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL midreset_hilo: got %h_%h want 0_0", hi, lo);
      end
      tick();
      reset = 1'b1;
      tick();
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL midreset_nocommit: got %h_%h want 0_0", hi, lo);
      end
      test_arith("postreset", 4'd1, 32'd9, 32'hFFFF_FFFF, MultCycles, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
   endtask

   task automatic ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rh, output logic [31:0] rl, output bit skip);
      longint p;
      longint q;
      longint r;
      skip = 1'b0;
      rh   = 32'd0;
      rl   = 32'd0;
      case (op)
         4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); rh = p[63:32]; rl = p[31:0]; end
         4'd2: begin p = longint'(a) * longint'(b); rh = p[63:32]; rl = p[31:0]; end
         4'd3: begin
            if (b == 32'd0) skip = 1'b1;
            else begin
               q = longint'($signed(a)) / longint'($signed(b));
               r = longint'($signed(a)) % longint'($signed(b));
               rl = q[31:0]; rh = r[31:0];
            end
         end
         4'd4: begin
            if (b == 32'd0) skip = 1'b1;
            else begin rl = a / b; rh = a % b; end
         end
         default: ;
      endcase
   endtask

   task automatic test_random();
      logic [31:0] hi_m, lo_m, pend_hi, pend_lo, exp_rd, a, b;
      logic [3:0]  op;
      bit          v, pend_skip, exp_stall, exp_start;
      int          rem, sel;
      reset = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      hi_m = 32'd0; lo_m = 32'd0; rem = 0; pend_hi = 32'd0; pend_lo = 32'd0; pend_skip = 1'b0;
      for (int n = 0; n < 800; n++) begin
         v   = ($urandom_range(0, 9) < 8);
         sel = $urandom_range(0, 19);
         op  = (sel < 17) ? 4'(1 + sel % 8) : 4'($urandom_range(0, 15));
         sel = $urandom_range(0, 7);
         a   = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'd0 : $urandom;
         sel = $urandom_range(0, 7);
         b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
               (sel == 2) ? 32'($urandom_range(1, 9)) : $urandom;
         drive(v, op, a, b);
         #1;
         exp_stall = v && op >= 4'd1 && op <= 4'd8 && rem > 0;
         exp_start = v && op >= 4'd1 && op <= 4'd4 && rem == 0;
         exp_rd    = !v ? 32'd0 : (op == 4'd5) ? hi_m : (op == 4'd6) ? lo_m : 32'd0;
         checks++; if (busy !== (rem > 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", n, busy, rem > 0); end
         checks++; if (stall_req !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", n, stall_req, exp_stall); end
         checks++; if (start !== exp_start) begin errors++; $display("FAIL rnd_start@%0d: got %b want %b", n, start, exp_start); end
         checks++; if (md_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, md_rdata, exp_rd); end
         checks++; if (hi !== hi_m || lo !== lo_m) begin
            errors++; $display("FAIL rnd_hilo@%0d: got %h_%h want %h_%h", n, hi, lo, hi_m, lo_m);
         end
         tick();
         if (rem > 0) begin
            rem--;
            if (rem == 0 && !pend_skip) begin hi_m = pend_hi; lo_m = pend_lo; end
         end else if (v) begin
            if (op >= 4'd1 && op <= 4'd4) begin
               ref_result(op, a, b, pend_hi, pend_lo, pend_skip);
               rem = (op <= 4'd2) ? MultCycles : DivCycles;
            end else if (op == 4'd7) hi_m = a;
            else if (op == 4'd8) lo_m = a;
         end
      end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      #2;
      test_reset();
      test_arith("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, MultCycles, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      test_arith("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, MultCycles, 32'h0000_0001, 32'hFFFF_FFFE);
      test_div_stall();
      test_arith("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DivCycles, 32'd0, 32'h8000_0000);
      test_arith("divu", 4'd4, 32'd100, 32'd7, DivCycles, 32'd2, 32'd14);
      test_noop_while_busy();
      test_divu_zero();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
